// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - instruction/data cache arbiter onto one RAM port (optional stats: ARB_STATS_EN)
module mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter logic [31:0] ERR_WORD     = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
`ifdef ARB_STATS_EN
  output logic [31:0] igrants,
  output logic [31:0] dgrants,
  output logic [31:0] stalls,
`endif
  output logic        err
);

  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, ISERV, DSERV} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          d_req;
  logic          i_done;
  logic          d_done;

  assign d_req = dREN | dWEN;

  // Registered grant state and data-streak counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Grant decision, live RAM drive and completion signalling
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    err      = 1'b0;
    i_done   = 1'b0;
    d_done   = 1'b0;
    if (!RST) begin
      case (state_q)
        IDLE: begin
          // Data wins unless it has starved a waiting instruction fetch
          if (d_req && (!iREN || streak_q != MAX_S)) begin
            state_d = DSERV;
          end else if (iREN) begin
            state_d = ISERV;
          end
        end
        ISERV: begin
          ramaddr = iaddr;
          if (iREN) begin
            ramREN = 1'b1;
            if (ramstate[1]) begin
              i_done   = 1'b1;
              iwait    = 1'b0;
              iload    = ramstate[0] ? ERR_WORD : ramload;
              err      = ramstate[0];
              streak_d = '0;
              state_d  = IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        DSERV: begin
          ramaddr  = daddr;
          ramstore = dstore;
          if (d_req) begin
            ramWEN = dWEN;
            ramREN = dREN & ~dWEN;
            if (ramstate[1]) begin
              d_done  = 1'b1;
              dwait   = 1'b0;
              dload   = ramstate[0] ? ERR_WORD : ramload;
              err     = ramstate[0];
              state_d = IDLE;
              if (!iREN) begin
                streak_d = '0;
              end else if (streak_q != MAX_S) begin
                streak_d = streak_q + SW'(1);
              end
            end
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] igrants_q, igrants_d;
  logic [31:0] dgrants_q, dgrants_d;
  logic [31:0] stalls_q, stalls_d;

  // Statistics next-values: completions per side and data-service stall cycles
  always_comb begin
    igrants_d = igrants_q + {31'd0, i_done};
    dgrants_d = dgrants_q + {31'd0, d_done};
    stalls_d  = stalls_q + {31'd0, (state_q == DSERV) && iREN};
  end

  // Statistics registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      igrants_q <= '0;
      dgrants_q <= '0;
      stalls_q  <= '0;
    end else begin
      igrants_q <= igrants_d;
      dgrants_q <= dgrants_d;
      stalls_q  <= stalls_d;
    end
  end

  assign igrants = igrants_q;
  assign dgrants = dgrants_q;
  assign stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int MAX = 4;
  localparam logic [31:0] ERRW = 32'hBAD1BAD1;

  logic        CLK, RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef ARB_STATS_EN
  logic [31:0] igrants, dgrants, stalls;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // reference: which side holds the grant (0 none, 1 instr, 2 data) and data streak
  int m_g = 0;
  int m_streak = 0;
  int m_ic = 0, m_dc = 0, m_st = 0;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
`ifdef ARB_STATS_EN
    .igrants(igrants), .dgrants(dgrants), .stalls(stalls),
`endif
    .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // advance the reference across one rising edge, then step 1 time unit past it
  task automatic tick();
    int  ng, ns;
    bit  act, done;
    ng = m_g;
    ns = m_streak;
    if (RST) begin
      ng = 0; ns = 0; m_ic = 0; m_dc = 0; m_st = 0;
    end else if (m_g == 0) begin
      if ((dREN || dWEN) && (!iREN || m_streak < MAX)) ng = 2;
      else if (iREN) ng = 1;
    end else begin
      act  = (m_g == 2) ? (dREN || dWEN) : iREN;
      done = act && ramstate[1];
      if (!act || done) ng = 0;
      if (done) begin
        if (m_g == 1) begin
          ns = 0; m_ic++;
        end else begin
          ns = iREN ? ((m_streak + 1 > MAX) ? MAX : m_streak + 1) : 0;
          m_dc++;
        end
      end
      if (m_g == 2 && iREN) m_st++;
    end
    @(posedge CLK);
    m_g = ng;
    m_streak = ns;
    #1;
  endtask

  task automatic test_reset();
    RST = 1; iREN = 1; dREN = 1; dWEN = 0; ramstate = 2'b10;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      n_cmp++;
      if ({iwait, dwait, ramREN, ramWEN, err} !== 5'b11000) begin
        n_bad++;
        $display("FAIL reset_ctl cyc%0d got %b want 11000", c, {iwait, dwait, ramREN, ramWEN, err});
      end
      tick();
    end
`ifdef ARB_STATS_EN
    n_cmp++;
    if ({igrants, dgrants, stalls} !== 96'd0) begin
      n_bad++;
      $display("FAIL reset_stats got %h want 0", {igrants, dgrants, stalls});
    end
`endif
    RST = 0; iREN = 0; dREN = 0; ramstate = 2'b00;
    tick();
  endtask

  task automatic test_instr_only();
    iREN = 1; iaddr = 32'h40; ramstate = 2'b00;
    @(negedge CLK);
    n_cmp++;
    if ({ramREN, iwait} !== 2'b01) begin
      n_bad++; $display("FAIL instr_arb_latency got %b want 01", {ramREN, iwait});
    end
    tick();
    for (int c = 0; c < 2; c++) begin
      ramstate = 2'b01;
      @(negedge CLK);
      n_cmp++;
      if ({ramREN, ramWEN, iwait, dwait} !== 4'b1011 || ramaddr !== 32'h40 || iload !== 32'h0) begin
        n_bad++;
        $display("FAIL instr_busy cyc%0d got %b addr %h load %h want 1011 addr 40 load 0",
                 c, {ramREN, ramWEN, iwait, dwait}, ramaddr, iload);
      end
      tick();
    end
    ramstate = 2'b10; ramload = 32'h8C220004;
    @(negedge CLK);
    n_cmp++;
    if (iwait !== 1'b0 || iload !== 32'h8C220004 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL instr_access got iwait %b iload %h err %b want 0 8c220004 0", iwait, iload, err);
    end
    tick();
    iREN = 0; ramstate = 2'b00;
    @(negedge CLK);
    n_cmp++;
    if ({ramREN, iwait} !== 2'b01 || iload !== 32'h0) begin
      n_bad++; $display("FAIL instr_idle got %b load %h want 01 0", {ramREN, iwait}, iload);
    end
    tick();
  endtask

  task automatic test_write_over_read();
    dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = 2'b00;
    tick();
    ramstate = 2'b01;
    @(negedge CLK);
    n_cmp++;
    if ({ramREN, ramWEN, dwait} !== 3'b011 || ramstore !== 32'hDEADBEEF || ramaddr !== 32'h100) begin
      n_bad++;
      $display("FAIL wr_drive got %b store %h addr %h want 011 deadbeef 100",
               {ramREN, ramWEN, dwait}, ramstore, ramaddr);
    end
    tick();
    ramstate = 2'b10;
    @(negedge CLK);
    n_cmp++;
    if (dwait !== 1'b0) begin
      n_bad++; $display("FAIL wr_done got dwait %b want 0", dwait);
    end
    tick();
    dREN = 0; dWEN = 0; ramstate = 2'b00;
    tick();
  endtask

  task automatic test_error_abort();
    dREN = 1; ramstate = 2'b00;
    tick();
    ramstate = 2'b11; ramload = 32'h12345678;
    @(negedge CLK);
    n_cmp++;
    if (dload !== ERRW || dwait !== 1'b0 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL error_done got dload %h dwait %b err %b want bad1bad1 0 1", dload, dwait, err);
    end
    tick();
    ramstate = 2'b00;
    @(negedge CLK);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL error_pulse got err %b want 0", err);
    end
    tick();
    ramstate = 2'b01;
    @(negedge CLK);
    n_cmp++;
    if (ramREN !== 1'b1) begin
      n_bad++; $display("FAIL abort_pre got ramREN %b want 1", ramREN);
    end
    dREN = 0;
    #1;
    n_cmp++;
    if ({ramREN, dwait} !== 2'b01) begin
      n_bad++; $display("FAIL abort_drop got %b want 01", {ramREN, dwait});
    end
    tick();
    dREN = 1;
    @(negedge CLK);
    n_cmp++;
    if ({ramREN, dwait} !== 2'b01) begin
      n_bad++; $display("FAIL abort_idle got %b want 01", {ramREN, dwait});
    end
    tick();
    dREN = 0;
    tick();
  endtask

  task automatic test_starvation();
    int seq[$];
    iREN = 1; dREN = 1; dWEN = 0; ramstate = 2'b10;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (!dwait) seq.push_back(0);
      if (!iwait) seq.push_back(1);
      tick();
    end
    iREN = 0; dREN = 0; ramstate = 2'b00;
    tick();
    n_cmp++;
    if (seq.size() < 12) begin
      n_bad++; $display("FAIL starve_count got %0d want >=12", seq.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        n_cmp++;
        if (seq[k] !== ((k % 5 == 4) ? 1 : 0)) begin
          n_bad++; $display("FAIL starve_order k%0d got %0d want %0d", k, seq[k], (k % 5 == 4) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_random();
    logic        e_iw, e_dw, e_ren, e_wen, e_err;
    logic [31:0] e_addr, e_store, e_il, e_dl;
    for (int c = 0; c < 600; c++) begin
      iREN     = ($urandom_range(0, 3) != 0);
      dREN     = $urandom_range(0, 1) == 1;
      dWEN     = ($urandom_range(0, 3) == 0);
      ramstate = 2'($urandom_range(0, 3));
      iaddr    = $urandom;
      daddr    = $urandom;
      dstore   = $urandom;
      ramload  = $urandom;
      @(negedge CLK);
      e_iw = 1; e_dw = 1; e_ren = 0; e_wen = 0; e_err = 0;
      e_addr = 0; e_store = 0; e_il = 0; e_dl = 0;
      if (m_g == 1) begin
        e_addr = iaddr;
        if (iREN) begin
          e_ren = 1;
          if (ramstate[1]) begin
            e_iw = 0; e_il = ramstate[0] ? ERRW : ramload; e_err = ramstate[0];
          end
        end
      end else if (m_g == 2) begin
        e_addr = daddr; e_store = dstore;
        if (dREN || dWEN) begin
          e_wen = dWEN; e_ren = dREN && !dWEN;
          if (ramstate[1]) begin
            e_dw = 0; e_dl = ramstate[0] ? ERRW : ramload; e_err = ramstate[0];
          end
        end
      end
      n_cmp++;
      if ({iwait, dwait, ramREN, ramWEN, err} !== {e_iw, e_dw, e_ren, e_wen, e_err}) begin
        n_bad++;
        $display("FAIL rand_ctl c%0d got %b want %b", c,
                 {iwait, dwait, ramREN, ramWEN, err}, {e_iw, e_dw, e_ren, e_wen, e_err});
      end
      n_cmp++;
      if (ramaddr !== e_addr || ramstore !== e_store) begin
        n_bad++;
        $display("FAIL rand_ram c%0d got %h/%h want %h/%h", c, ramaddr, ramstore, e_addr, e_store);
      end
      n_cmp++;
      if (iload !== e_il || dload !== e_dl) begin
        n_bad++;
        $display("FAIL rand_load c%0d got %h/%h want %h/%h", c, iload, dload, e_il, e_dl);
      end
      tick();
    end
    iREN = 0; dREN = 0; dWEN = 0; ramstate = 2'b00;
    tick();
`ifdef ARB_STATS_EN
    n_cmp++;
    if (igrants !== 32'(m_ic) || dgrants !== 32'(m_dc) || stalls !== 32'(m_st)) begin
      n_bad++;
      $display("FAIL stats got %0d/%0d/%0d want %0d/%0d/%0d",
               igrants, dgrants, stalls, m_ic, m_dc, m_st);
    end
`endif
  endtask

  initial begin
    RST = 1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'b00;
    test_reset();
    test_instr_only();
    test_write_over_read();
    test_error_abort();
    test_starvation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Downstream neighbour of the instruction cache.
- Arbitrates the single-core instruction-cache fill port (iREN/iaddr) and the data-cache port (dREN/dWEN/daddr/dstore) onto one RAM port.
- Returns iwait/dwait/iload/dload to the caches.
- Data cache has priority, bounded by an anti-starvation streak limit so instruction fetch always progresses.

Parameters:
MAX_D_STREAK, 4, consecutive data grants allowed while an instruction request is pending before the instruction side is forced.
ERR_WORD, 32'hBAD1BAD1, value returned on iload/dload when RAM reports ERROR.

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous active-high reset
iREN  input  1  instruction-cache read request
iaddr  input  32  instruction word address
iwait  output  1  instruction request not yet complete
iload  output  32  instruction read data
dREN  input  1  data-cache read request
dWEN  input  1  data-cache write request
daddr  input  32  data address
dstore  input  32  data write value
dwait  output  1  data request not yet complete
dload  output  32  data read data
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data
ramstate  input  2  00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR
err  output  1  one-cycle pulse on ERROR completion

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST). On RST=1 at a rising edge: state=IDLE, streak=0, err=0.
- Outputs while in reset and in IDLE: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
- States: IDLE, ISERV, DSERV. The grant is registered, giving one cycle of arbitration latency from request to RAM enable.
- IDLE transitions:
  - (dREN|dWEN) and (!iREN or streak<MAX_D_STREAK) -> DSERV.
  - else iREN -> ISERV.
  - else stay in IDLE.
- DSERV:
  - ramaddr=daddr, ramstore=dstore.
  - dWEN=1 -> ramWEN=1, ramREN=0. Write wins if both dREN and dWEN are high.
  - otherwise ramREN=dREN.
- ISERV: ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
- Completion is combinational in the cycle ramstate==ACCESS while granted:
  - Granted side's wait goes to 0 for exactly that cycle.
  - Granted side's load is driven from ramload.
  - Next state is IDLE.
- ramstate==ERROR while granted: same as completion, but the load value is ERR_WORD and err=1 for that cycle.
- FREE or BUSY while granted: wait stays 1, load is 0, state holds.
- Non-granted side: wait=1, load=0 at all times.
- Request withdrawn mid-service (granted side's enables all 0): next state IDLE, RAM enables drop in that cycle, no completion, streak unchanged.
- Streak counter, width clog2(MAX_D_STREAK+1):
  - Data completion with iREN=1 in that cycle: increment, saturating at MAX_D_STREAK.
  - Data completion with iREN=0: clear.
  - Any instruction completion: clear.
- Back-to-back: at least one IDLE cycle separates consecutive grants. Worst-case instruction latency is bounded by MAX_D_STREAK data services plus one.
- Inputs are sampled only in IDLE (grant decision) and for the live RAM drive; address changes during service pass straight through to ramaddr.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined: adds output ports igrants (32), dgrants (32) and stalls (32). Each counter resets to 0 and wraps modulo 2^32.
  - igrants/dgrants increment on each instruction/data completion, ERROR included.
  - stalls increments every cycle iREN=1 while in DSERV.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: RST=1 for 2 cycles with iREN=1, dREN=1 -> iwait=1, dwait=1, ramREN=0, ramWEN=0, err=0 throughout.
- Instruction only: iREN=1, iaddr=0x40; RAM gives BUSY 2 cycles then ACCESS with ramload=0x8C220004 -> ramaddr=0x40 from cycle 2; iwait=0 and iload=0x8C220004 only in the ACCESS cycle; back to IDLE.
- Write-over-read: dREN=1, dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait=0 on ACCESS.
- Starvation bound (MAX_D_STREAK=4): iREN held 1 with data requests continuously re-asserted -> exactly 4 data completions, then ISERV grant; iwait falls on the 5th service; streak=0 afterwards.
- Error and abort: during DSERV, ramstate=ERROR -> dload=0xBAD1BAD1, dwait=0, err=1 for one cycle. Separately, dREN dropped mid-DSERV -> ramREN=0 that cycle, dwait stays 1, IDLE next cycle.
- ARB_STATS_EN build: 3 instruction and 2 data completions -> igrants=3, dgrants=2; stalls equals the DSERV cycles spent with iREN=1.
